// File: rtl/n_to_m_mux_reg_pkg.sv
// Shared constants and helpers for the registered N_IN-to-N_OUT multiplexer.
// Holds default lane geometry, the clog2 rule and the reset-select rule.
package n_to_m_mux_reg_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_N_IN  = 3;
    localparam int DEF_N_OUT = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Select/address ports are never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int reset_sel(input int k, input int n_in);
        return k % n_in;
    endfunction

endpackage

// File: rtl/n_to_m_mux_reg_lane_slice.sv
// One output lane: shadow/active select registers, commit/rotate update
// and the WIDTH-bit output register.
module mux_lane_slice
    import n_to_m_mux_reg_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_IN    = DEF_N_IN,
    parameter int SEL_W   = clog2_min1(DEF_N_IN),
    parameter int RST_SEL = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_IN*WIDTH-1:0]   x,
    input  logic                    in_valid,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_data,
    input  logic                    commit,
    input  logic                    rot_en,
    output logic [WIDTH-1:0]        o
);

    localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RST_SEL);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] shadow_q, shadow_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] picked;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        picked = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (active_q == SEL_W'(i)) picked = x[i*WIDTH +: WIDTH];
        end

        shadow_d = wr_en ? wr_data : shadow_q;
        o_d      = in_valid ? picked : o_q;

        // Commit takes shadow_d so a same-cycle write is part of the commit.
        if (commit) begin
            active_d = shadow_d;
        end else if (rot_en && in_valid) begin
            active_d = (active_q == SEL_LAST) ? '0 : active_q + SEL_W'(1);
        end else begin
            active_d = active_q;
        end
    end

    // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= SEL_RST;
            active_q <= SEL_RST;
            o_q      <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            o_q      <= o_d;
        end
    end

    assign o = o_q;

endmodule

// File: rtl/n_to_m_mux_reg.sv
// Registered N_IN-to-N_OUT multiplexer with shadow/commit select loading
// and an optional round-robin rotate mode; one pipeline stage of latency.
module n_to_m_mux_reg
    import n_to_m_mux_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    localparam int SEL_W  = clog2_min1(N_IN),
    localparam int ADDR_W = clog2_min1(N_OUT)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_IN*WIDTH-1:0]   X,
    input  logic                    IN_VALID,
    input  logic                    SEL_WE,
    input  logic [ADDR_W-1:0]       SEL_ADDR,
    input  logic [SEL_W-1:0]        SEL_DATA,
    input  logic                    COMMIT,
    input  logic                    ROT_EN,
    output logic [N_OUT*WIDTH-1:0]  O,
    output logic                    O_VALID,
    output logic                    SEL_ERR
);

    logic             addr_ok, data_ok, wr_ok;
    logic [N_OUT-1:0] lane_we;
    logic             o_valid_q, o_valid_d;
    logic             sel_err_q, sel_err_d;

    always_comb begin
        addr_ok   = int'(SEL_ADDR) < N_OUT;
        data_ok   = int'(SEL_DATA) < N_IN;
        wr_ok     = SEL_WE && addr_ok && data_ok;
        sel_err_d = SEL_WE && !(addr_ok && data_ok);
        o_valid_d = IN_VALID;
        lane_we   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            lane_we[k] = wr_ok && (SEL_ADDR == ADDR_W'(k));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        mux_lane_slice #(
            .WIDTH   (WIDTH),
            .N_IN    (N_IN),
            .SEL_W   (SEL_W),
            .RST_SEL (reset_sel(k, N_IN))
        ) u_lane (
            .CLK      (CLK),
            .RST      (RST),
            .x        (X),
            .in_valid (IN_VALID),
            .wr_en    (lane_we[k]),
            .wr_data  (SEL_DATA),
            .commit   (COMMIT),
            .rot_en   (ROT_EN),
            .o        (O[k*WIDTH +: WIDTH])
        );
    end

    assign O_VALID = o_valid_q;
    assign SEL_ERR = sel_err_q;

endmodule

// File: tb/tb_n_to_m_mux_reg.sv
// Randomised scoreboard bench for n_to_m_mux_reg, with a directed preamble
// covering reset, shadow isolation, bad config, rotate, collision and mid-run reset.
module tb_n_to_m_mux_reg;

    localparam int WIDTH  = 2;
    localparam int N_IN   = 3;
    localparam int N_OUT  = 2;
    localparam int SEL_W  = 2;
    localparam int ADDR_W = 1;
    localparam int XW     = N_IN * WIDTH;
    localparam int OW     = N_OUT * WIDTH;
    localparam logic [XW-1:0] X321 = 6'b11_10_01;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [XW-1:0]     X = '0;
    logic              IN_VALID = 1'b0;
    logic              SEL_WE = 1'b0;
    logic [ADDR_W-1:0] SEL_ADDR = '0;
    logic [SEL_W-1:0]  SEL_DATA = '0;
    logic              COMMIT = 1'b0;
    logic              ROT_EN = 1'b0;
    logic [OW-1:0]     O;
    logic              O_VALID;
    logic              SEL_ERR;

    always #5 CLK = ~CLK;

    n_to_m_mux_reg #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .CLK(CLK), .RST(RST), .X(X), .IN_VALID(IN_VALID), .SEL_WE(SEL_WE),
        .SEL_ADDR(SEL_ADDR), .SEL_DATA(SEL_DATA), .COMMIT(COMMIT), .ROT_EN(ROT_EN),
        .O(O), .O_VALID(O_VALID), .SEL_ERR(SEL_ERR)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: which input lane each output lane reads.
    int            active[N_OUT];
    int            shadow[N_OUT];
    logic [OW-1:0] sb[$];
    logic          exp_valid = 1'b0;
    logic          exp_err   = 1'b0;
    logic [OW-1:0] exp_hold  = '0;
    bit            started   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then wait until after the edge.
    task automatic step(input bit rst, input logic [XW-1:0] x, input bit v,
                        input bit we, input int addr, input int data,
                        input bit commit, input bit rot);
        int xv;
        int sample;
        bit ok;
        RST      = rst;
        X        = x;
        IN_VALID = v;
        SEL_WE   = we;
        SEL_ADDR = addr[ADDR_W-1:0];
        SEL_DATA = data[SEL_W-1:0];
        COMMIT   = commit;
        ROT_EN   = rot;
        xv = int'(x);
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                active[k] = k % N_IN;
                shadow[k] = k % N_IN;
            end
            exp_hold  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            ok        = (addr < N_OUT) && (data < N_IN);
            exp_valid = v;
            exp_err   = we && !ok;
            if (v) begin
                sample = 0;
                for (int k = 0; k < N_OUT; k++)
                    sample |= ((xv >> (active[k] * WIDTH)) & ((1 << WIDTH) - 1)) << (k * WIDTH);
                sb.push_back(OW'(sample));
                exp_hold = OW'(sample);
            end
            if (we && ok) shadow[addr] = data;
            if (commit) begin
                for (int k = 0; k < N_OUT; k++) active[k] = shadow[k];
            end else if (rot && v) begin
                for (int k = 0; k < N_OUT; k++) active[k] = (active[k] + 1) % N_IN;
            end
        end
        started = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_o(input string name, input int e0, input int e1);
        check({name, "_o0"}, int'(O[1:0]), e0);
        check({name, "_o1"}, int'(O[3:2]), e1);
    endtask

    // Monitor: every cycle after an edge, compare flags and data against the scoreboard.
    always @(negedge CLK) begin
        if (started) begin
            check("o_valid", int'(O_VALID), int'(exp_valid));
            check("sel_err", int'(SEL_ERR), int'(exp_err));
            if (O_VALID) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got valid output, want none pending (t=%0t)", $time);
                end else begin
                    check("o_data", int'(O), int'(sb.pop_front()));
                end
            end else begin
                check("o_hold", int'(O), int'(exp_hold));
            end
        end
    end

    initial begin
        // 1: reset and first sample
        step(1, '0, 0, 0, 0, 0, 0, 0);
        step(1, '0, 0, 0, 0, 0, 0, 0);
        expect_o("reset", 0, 0);
        check("reset_valid", int'(O_VALID), 0);
        check("reset_err", int'(SEL_ERR), 0);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        expect_o("first", 1, 2);
        check("first_valid", int'(O_VALID), 1);

        // 2: shadow isolation, then commit
        step(0, X321, 1, 1, 0, 2, 0, 0);
        expect_o("shadow_wr", 1, 2);
        step(0, X321, 1, 0, 0, 0, 1, 0);
        expect_o("commit_edge", 1, 2);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        expect_o("after_commit", 3, 2);
        step(0, X321, 0, 1, 0, 0, 1, 0);

        // 3: out-of-range data rejected
        step(0, X321, 1, 1, 0, 3, 0, 0);
        check("bad_cfg_err", int'(SEL_ERR), 1);
        expect_o("bad_cfg", 1, 2);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        check("bad_cfg_err_clear", int'(SEL_ERR), 0);
        expect_o("bad_cfg_after", 1, 2);

        // 4: rotate with wrap, then pause when IN_VALID=0
        step(0, X321, 1, 0, 0, 0, 0, 1);
        expect_o("rot0", 1, 2);
        step(0, X321, 1, 0, 0, 0, 0, 1);
        expect_o("rot1", 2, 3);
        step(0, X321, 1, 0, 0, 0, 0, 1);
        expect_o("rot2", 3, 1);
        step(0, X321, 1, 0, 0, 0, 0, 1);
        expect_o("rot3", 1, 2);
        step(0, X321, 0, 0, 0, 0, 0, 1);
        expect_o("rot_pause", 1, 2);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        expect_o("rot_paused_sel", 2, 3);
        step(0, X321, 0, 0, 0, 0, 1, 0);

        // 5: write + commit + rotate collide
        step(0, X321, 1, 1, 1, 0, 1, 1);
        expect_o("collide_edge", 1, 2);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        expect_o("collide_after", 1, 1);

        // 6: reset in the middle of rotating with a pending write
        step(0, X321, 1, 1, 0, 2, 0, 1);
        step(1, X321, 1, 1, 1, 2, 0, 1);
        expect_o("mid_reset", 0, 0);
        check("mid_reset_valid", int'(O_VALID), 0);
        step(0, X321, 1, 0, 0, 0, 0, 0);
        expect_o("post_reset", 1, 2);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(49) == 0, XW'($urandom), $urandom_range(3) != 0,
                 $urandom_range(2) == 0, int'($urandom_range(1)), int'($urandom_range(3)),
                 $urandom_range(7) == 0, $urandom_range(1) == 1);
        end
        step(0, '0, 0, 0, 0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
